// File: rtl/fir_ctrl_regs_pkg.sv
// Shared definitions for the FIR control block: register word indices,
// CTRL/ISR bit positions, frame sequencer states and byte-lane mask helper.
package fir_ctrl_regs_pkg;

  localparam logic [5:0] W_CTRL   = 6'h00;
  localparam logic [5:0] W_STATUS = 6'h01;
  localparam logic [5:0] W_ISR    = 6'h02;
  localparam logic [5:0] W_DIM    = 6'h03;
  localparam logic [5:0] W_SHIFT  = 6'h04;
  localparam logic [5:0] W_PIXCNT = 6'h05;
  localparam logic [5:0] W_COEF0  = 6'h08;

  localparam int unsigned CTRL_START  = 0;
  localparam int unsigned CTRL_ABORT  = 1;
  localparam int unsigned CTRL_IRQ_EN = 2;
  localparam int unsigned ISR_DONE    = 0;
  localparam int unsigned ISR_ABORTED = 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_RUN,
    ST_DONE
  } seq_state_t;

  function automatic logic [31:0] strb_mask(input logic [3:0] strb);
    logic [31:0] m;
    m = '0;
    for (int unsigned b = 0; b < 4; b++) begin
      m[8*b +: 8] = {8{strb[b]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/fir_ctrl_regs_frame_seq.sv
// Frame sequencer: IDLE/LAUNCH/RUN/DONE FSM with column/row position and
// output-pixel counter; end of frame found by col/row compare only.
module fir_frame_seq
  import fir_ctrl_regs_pkg::*;
#(
  parameter int unsigned DIM_BITS = 11
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic [DIM_BITS-1:0]     width,
  input  logic [DIM_BITS-1:0]     height,
  input  logic                    pix_out_valid,
  output seq_state_t              state,
  output logic                    frame_start,
  output logic                    filt_en,
  output logic                    done_p,
  output logic                    abort_p,
  output logic [2*DIM_BITS-1:0]   pixcnt
);

  seq_state_t              r_state;
  seq_state_t              w_next;
  logic [DIM_BITS-1:0]     r_col;
  logic [DIM_BITS-1:0]     r_row;
  logic [2*DIM_BITS-1:0]   r_pixcnt;
  logic                    w_go;
  logic                    w_pix;
  logic                    w_col_last;
  logic                    w_row_last;

  // ABORT in the same write as START suppresses the launch
  assign w_go       = start & ~abort & (width != '0) & (height != '0);
  assign w_pix      = (r_state == ST_RUN) & pix_out_valid & ~abort;
  assign w_col_last = (r_col == width - DIM_BITS'(1));
  assign w_row_last = (r_row == height - DIM_BITS'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_go) w_next = ST_LAUNCH;
      ST_LAUNCH: w_next = abort ? ST_IDLE : ST_RUN;
      ST_RUN: begin
        if (abort) begin
          w_next = ST_IDLE;
        end else if (w_pix && w_col_last && w_row_last) begin
          w_next = ST_DONE;
        end
      end
      ST_DONE:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col    <= '0;
      r_row    <= '0;
      r_pixcnt <= '0;
    end else if (r_state == ST_IDLE && w_go) begin
      r_col    <= '0;
      r_row    <= '0;
      r_pixcnt <= '0;
    end else if (w_pix) begin
      r_pixcnt <= r_pixcnt + (2*DIM_BITS)'(1);
      if (w_col_last) begin
        r_col <= '0;
        r_row <= r_row + DIM_BITS'(1);
      end else begin
        r_col <= r_col + DIM_BITS'(1);
      end
    end
  end

  assign state       = r_state;
  assign frame_start = (r_state == ST_LAUNCH);
  assign filt_en     = (r_state == ST_RUN);
  assign done_p      = (r_state == ST_DONE);
  assign abort_p     = abort & ((r_state == ST_LAUNCH) | (r_state == ST_RUN));
  assign pixcnt      = r_pixcnt;

endmodule

// File: rtl/fir_ctrl_regs.sv
// FIR filter register bank: byte-strobed register decode, config lock while
// a frame runs, ISR/irq handling and combinational read mux.
module fir_ctrl_regs
  import fir_ctrl_regs_pkg::*;
#(
  parameter int unsigned COEF_BITS = 8,
  parameter int unsigned DIM_BITS  = 11,
  parameter int unsigned NUM_COEF  = 9
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    wr_addr,
  input  logic                          wr_en,
  input  logic [31:0]                   wr_data,
  input  logic [3:0]                    wr_strb,
  input  logic [7:0]                    rd_addr,
  input  logic                          rd_en,
  output logic [31:0]                   rd_data,
  output logic [NUM_COEF*COEF_BITS-1:0] cfg_coef,
  output logic [3:0]                    cfg_shift,
  output logic [DIM_BITS-1:0]           img_width,
  output logic [DIM_BITS-1:0]           img_height,
  output logic                          frame_start,
  output logic                          filt_en,
  input  logic                          pix_out_valid,
  output logic                          irq
);

  logic [COEF_BITS-1:0]  r_coef [NUM_COEF];
  logic [DIM_BITS-1:0]   r_width;
  logic [DIM_BITS-1:0]   r_height;
  logic [3:0]            r_shift;
  logic                  r_irq_en;
  logic [1:0]            r_isr;
  logic                  r_irq;

  logic [5:0]            w_wr_word;
  logic [5:0]            w_rd_word;
  logic [31:0]           w_wmask;
  logic                  w_ctrl_wr;
  logic                  w_start;
  logic                  w_abort;
  logic                  w_cfg_wr;
  logic                  w_busy;
  logic [1:0]            w_isr_clr;
  logic [1:0]            w_isr_set;
  seq_state_t            w_state;
  logic                  w_done_p;
  logic                  w_abort_p;
  logic [2*DIM_BITS-1:0] w_pixcnt;
  logic                  w_unused;

  assign w_wr_word = wr_addr[7:2];
  assign w_rd_word = rd_addr[7:2];
  assign w_wmask   = strb_mask(wr_strb);
  assign w_busy    = (w_state != ST_IDLE);
  assign w_ctrl_wr = wr_en & (w_wr_word == W_CTRL) & wr_strb[0];
  assign w_start   = w_ctrl_wr & wr_data[CTRL_START];
  assign w_abort   = w_ctrl_wr & wr_data[CTRL_ABORT];
  assign w_cfg_wr  = wr_en & ~w_busy;
  assign w_isr_clr = (wr_en && w_wr_word == W_ISR && wr_strb[0]) ? wr_data[1:0] : '0;
  assign w_isr_set = {w_abort_p, w_done_p};
  assign w_unused  = ^{rd_en, wr_addr[1:0], rd_addr[1:0], wr_data, w_wmask};

  fir_frame_seq #(
    .DIM_BITS (DIM_BITS)
  ) u_seq (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (w_start),
    .abort         (w_abort),
    .width         (r_width),
    .height        (r_height),
    .pix_out_valid (pix_out_valid),
    .state         (w_state),
    .frame_start   (frame_start),
    .filt_en       (filt_en),
    .done_p        (w_done_p),
    .abort_p       (w_abort_p),
    .pixcnt        (w_pixcnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_width  <= '0;
      r_height <= '0;
      r_shift  <= '0;
      r_irq_en <= 1'b0;
      r_isr    <= '0;
      r_irq    <= 1'b0;
      for (int unsigned k = 0; k < NUM_COEF; k++) begin
        r_coef[k] <= '0;
      end
    end else begin
      if (w_ctrl_wr) r_irq_en <= wr_data[CTRL_IRQ_EN];
      // hardware set dominates a simultaneous W1C
      r_isr <= (r_isr & ~w_isr_clr) | w_isr_set;
      r_irq <= r_irq_en & (|r_isr);
      if (w_cfg_wr && w_wr_word == W_DIM) begin
        r_width  <= (r_width & ~w_wmask[DIM_BITS-1:0]) |
                    (wr_data[DIM_BITS-1:0] & w_wmask[DIM_BITS-1:0]);
        r_height <= (r_height & ~w_wmask[16 +: DIM_BITS]) |
                    (wr_data[16 +: DIM_BITS] & w_wmask[16 +: DIM_BITS]);
      end
      if (w_cfg_wr && w_wr_word == W_SHIFT) begin
        r_shift <= (r_shift & ~w_wmask[3:0]) | (wr_data[3:0] & w_wmask[3:0]);
      end
      for (int unsigned k = 0; k < NUM_COEF; k++) begin
        if (w_cfg_wr && w_wr_word == W_COEF0 + 6'(k)) begin
          r_coef[k] <= (r_coef[k] & ~w_wmask[COEF_BITS-1:0]) |
                       (wr_data[COEF_BITS-1:0] & w_wmask[COEF_BITS-1:0]);
        end
      end
    end
  end

  always_comb begin
    rd_data = '0;
    case (w_rd_word)
      W_CTRL:   rd_data[CTRL_IRQ_EN] = r_irq_en;
      W_STATUS: rd_data[1:0] = {2{w_busy}};
      W_ISR:    rd_data[1:0] = r_isr;
      W_DIM: begin
        rd_data[DIM_BITS-1:0]    = r_width;
        rd_data[16 +: DIM_BITS]  = r_height;
      end
      W_SHIFT:  rd_data[3:0] = r_shift;
      W_PIXCNT: rd_data[2*DIM_BITS-1:0] = w_pixcnt;
      default: begin
        for (int unsigned k = 0; k < NUM_COEF; k++) begin
          if (w_rd_word == W_COEF0 + 6'(k)) begin
            rd_data = {{(32-COEF_BITS){r_coef[k][COEF_BITS-1]}}, r_coef[k]};
          end
        end
      end
    endcase
  end

  always_comb begin
    cfg_coef = '0;
    for (int unsigned k = 0; k < NUM_COEF; k++) begin
      cfg_coef[k*COEF_BITS +: COEF_BITS] = r_coef[k];
    end
  end

  assign cfg_shift  = r_shift;
  assign img_width  = r_width;
  assign img_height = r_height;
  assign irq        = r_irq;

endmodule

// File: tb/tb_fir_ctrl_regs.sv
// Self-checking bench for fir_ctrl_regs against a register-level reference model.
module tb_fir_ctrl_regs;

  localparam int CB = 8;
  localparam int DB = 11;
  localparam int NC = 9;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [7:0]     wr_addr = '0;
  logic           wr_en = 1'b0;
  logic [31:0]    wr_data = '0;
  logic [3:0]     wr_strb = '0;
  logic [7:0]     rd_addr = '0;
  logic           rd_en = 1'b0;
  logic [31:0]    rd_data;
  logic [NC*CB-1:0] cfg_coef;
  logic [3:0]     cfg_shift;
  logic [DB-1:0]  img_width;
  logic [DB-1:0]  img_height;
  logic           frame_start;
  logic           filt_en;
  logic           pix_out_valid = 1'b0;
  logic           irq;

  always #5 clk = ~clk;

  fir_ctrl_regs #(
    .COEF_BITS (CB),
    .DIM_BITS  (DB),
    .NUM_COEF  (NC)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wr_addr       (wr_addr),
    .wr_en         (wr_en),
    .wr_data       (wr_data),
    .wr_strb       (wr_strb),
    .rd_addr       (rd_addr),
    .rd_en         (rd_en),
    .rd_data       (rd_data),
    .cfg_coef      (cfg_coef),
    .cfg_shift     (cfg_shift),
    .img_width     (img_width),
    .img_height    (img_height),
    .frame_start   (frame_start),
    .filt_en       (filt_en),
    .pix_out_valid (pix_out_valid),
    .irq           (irq)
  );

  // reference model state
  logic [7:0]  m_coef [NC];
  logic [10:0] m_w, m_h;
  logic [3:0]  m_shift;
  logic        m_irqen;
  logic [1:0]  m_isr;
  logic        m_busy;
  int unsigned m_pixcnt;

  int total = 0;
  int bad = 0;

  task automatic model_reset();
    for (int k = 0; k < NC; k++) m_coef[k] = '0;
    m_w = '0; m_h = '0; m_shift = '0; m_irqen = 1'b0;
    m_isr = '0; m_busy = 1'b0; m_pixcnt = 0;
  endtask

  function automatic logic [31:0] exp_rd(input logic [7:0] a);
    int w;
    w = int'(a[7:2]);
    case (w)
      0: return {29'd0, m_irqen, 2'b00};
      1: return m_busy ? 32'd3 : 32'd0;
      2: return {30'd0, m_isr};
      3: return {5'd0, m_h, 5'd0, m_w};
      4: return {28'd0, m_shift};
      5: return m_pixcnt;
      default: begin
        if (w >= 8 && w < 8 + NC) return 32'($signed(m_coef[w-8]));
        return 32'd0;
      end
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] img;
    int w;
    wr_addr = a; wr_data = d; wr_strb = s; wr_en = 1'b1;
    step();
    wr_en = 1'b0;
    w = int'(a[7:2]);
    case (w)
      0: if (s[0]) m_irqen = d[2];
      2: if (s[0]) m_isr = m_isr & ~d[1:0];
      3: if (!m_busy) begin
        img = {5'd0, m_h, 5'd0, m_w};
        for (int b = 0; b < 4; b++) if (s[b]) img[8*b +: 8] = d[8*b +: 8];
        m_w = img[10:0];
        m_h = img[26:16];
      end
      4: if (!m_busy && s[0]) m_shift = d[3:0];
      default: if (!m_busy && s[0] && w >= 8 && w < 8 + NC) m_coef[w-8] = d[7:0];
    endcase
  endtask

  task automatic rd_chk(input logic [7:0] a, input string tag);
    rd_addr = a; rd_en = 1'b1;
    #1;
    check(tag, rd_data, exp_rd(a));
    rd_en = 1'b0;
    step();
  endtask

  task automatic chk_cfg(input string tag);
    for (int k = 0; k < NC; k++) begin
      check($sformatf("%s_coef%0d", tag, k), 32'(cfg_coef[k*CB +: CB]), 32'(m_coef[k]));
    end
    check({tag, "_shift"}, 32'(cfg_shift), 32'(m_shift));
    check({tag, "_width"}, 32'(img_width), 32'(m_w));
    check({tag, "_height"}, 32'(img_height), 32'(m_h));
  endtask

  task automatic pix();
    pix_out_valid = 1'b1;
    step();
    pix_out_valid = 1'b0;
  endtask

  task automatic start_frame();
    wr(8'h00, 32'h1 | (32'(m_irqen) << 2), 4'h1);
    m_busy = 1'b1;
    m_pixcnt = 0;
    check("launch_fs", 32'(frame_start), 32'd1);
    check("launch_en", 32'(filt_en), 32'd0);
    step();
    check("run_fs", 32'(frame_start), 32'd0);
    check("run_en", 32'(filt_en), 32'd1);
  endtask

  task automatic run_pixels(input int unsigned n);
    repeat (n) begin
      repeat ($urandom_range(0, 2)) step();
      check("pix_en", 32'(filt_en), 32'd1);
      pix();
      m_pixcnt++;
    end
  endtask

  task automatic finish_frame();
    logic [1:0] isr_before;
    run_pixels(m_w * m_h);
    check("done_en", 32'(filt_en), 32'd0);
    check("done_fs", 32'(frame_start), 32'd0);
    isr_before = m_isr;
    step();
    m_busy = 1'b0;
    m_isr[0] = 1'b1;
    check("irq_lag", 32'(irq), 32'(m_irqen & (|isr_before)));
    step();
    check("irq_set", 32'(irq), 32'(m_irqen & (|m_isr)));
    rd_chk(8'h08, "isr_done");
    rd_chk(8'h04, "status_idle");
    rd_chk(8'h14, "pixcnt_done");
  endtask

  initial begin
    logic [7:0] a;
    model_reset();

    // 1. reset state and basic register access
    #1;
    check("rst_fs", 32'(frame_start), 32'd0);
    check("rst_en", 32'(filt_en), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    repeat (2) step();
    rst_n = 1'b1;
    step();
    chk_cfg("rst");
    for (int i = 0; i < 64; i++) begin
      a = 8'(i * 4);
      rd_chk(a, $sformatf("rst_rd_%02h", a));
    end
    wr(8'h2C, 32'h0000_00FF, 4'hF);
    rd_chk(8'h2C, "coef3_sx");
    wr(8'h0C, 32'h0123_0456, 4'b0011);
    rd_chk(8'h0C, "dim_strb");
    chk_cfg("strb");

    // randomized config writes including unmapped offsets
    for (int i = 0; i < 12; i++) begin
      case ($urandom_range(0, 3))
        0: a = 8'h0C;
        1: a = 8'h10;
        2: a = 8'(8'h20 + 4 * $urandom_range(0, NC - 1));
        default: a = 8'(4 * $urandom_range(17, 63));
      endcase
      wr(a, $urandom, 4'($urandom_range(0, 15)));
      rd_chk(a, $sformatf("rnd_rd_%02h", a));
    end
    chk_cfg("rnd");

    // 2. directed 4x2 frame with irq
    wr(8'h0C, {5'd0, 11'd2, 5'd0, 11'd4}, 4'hF);
    wr(8'h00, 32'h4, 4'h1);
    start_frame();
    run_pixels(3);
    rd_chk(8'h14, "pixcnt_mid");
    rd_chk(8'h04, "status_busy");
    run_pixels(1);
    m_pixcnt = m_pixcnt;
    begin
      logic [1:0] isr_before;
      run_pixels(4);
      check("done_en4", 32'(filt_en), 32'd0);
      isr_before = m_isr;
      step();
      m_busy = 1'b0;
      m_isr[0] = 1'b1;
      check("irq_lag4", 32'(irq), 32'(m_irqen & (|isr_before)));
      step();
      check("irq_4x2", 32'(irq), 32'd1);
      rd_chk(8'h08, "isr_4x2");
      rd_chk(8'h14, "pixcnt_4x2");
      rd_chk(8'h04, "status_4x2");
    end

    // randomized frame sizes
    for (int f = 0; f < 3; f++) begin
      wr(8'h08, 32'h3, 4'h1);
      wr(8'h0C, {5'd0, 11'($urandom_range(1, 4)), 5'd0, 11'($urandom_range(1, 5))}, 4'hF);
      start_frame();
      finish_frame();
    end

    // 3. locked config and abort mid-frame
    wr(8'h08, 32'h3, 4'h1);
    wr(8'h0C, {5'd0, 11'd2, 5'd0, 11'd4}, 4'hF);
    start_frame();
    run_pixels(3);
    rd_chk(8'h14, "abort_pix3");
    wr(8'h20, 32'h5, 4'hF);
    rd_chk(8'h20, "coef0_locked");
    wr(8'h0C, 32'h0, 4'hF);
    rd_chk(8'h0C, "dim_locked");
    wr(8'h00, 32'h6, 4'h1);
    m_busy = 1'b0;
    m_isr[1] = 1'b1;
    check("abort_en", 32'(filt_en), 32'd0);
    rd_chk(8'h08, "isr_aborted");
    rd_chk(8'h04, "status_abort");
    rd_chk(8'h14, "pixcnt_hold");
    check("irq_abort", 32'(irq), 32'd1);

    // 4. zero dimension, START+ABORT, pixels while idle
    wr(8'h0C, {5'd0, 11'd2, 5'd0, 11'd0}, 4'hF);
    wr(8'h00, 32'h5, 4'h1);
    check("zdim_fs", 32'(frame_start), 32'd0);
    rd_chk(8'h04, "zdim_status");
    wr(8'h0C, {5'd0, 11'd2, 5'd0, 11'd3}, 4'hF);
    wr(8'h00, 32'h7, 4'h1);
    check("sa_fs", 32'(frame_start), 32'd0);
    rd_chk(8'h04, "sa_status");
    rd_chk(8'h08, "sa_isr");
    pix();
    rd_chk(8'h14, "idle_pix");

    // 5. W1C colliding with DONE, then a clean W1C
    wr(8'h08, 32'h3, 4'h1);
    wr(8'h0C, {5'd0, 11'd1, 5'd0, 11'd1}, 4'hF);
    step();
    check("irq_clr", 32'(irq), 32'd0);
    start_frame();
    pix();
    m_pixcnt = 1;
    check("coll_done_en", 32'(filt_en), 32'd0);
    wr(8'h08, 32'h1, 4'h1);
    m_busy = 1'b0;
    m_isr[0] = 1'b1;
    rd_chk(8'h08, "isr_set_wins");
    check("irq_coll", 32'(irq), 32'd1);
    wr(8'h08, 32'h1, 4'h1);
    check("irq_still", 32'(irq), 32'd1);
    step();
    check("irq_drop", 32'(irq), 32'd0);
    rd_chk(8'h08, "isr_cleared");

    // 6. asynchronous reset mid-frame, then a full frame
    wr(8'h0C, {5'd0, 11'd2, 5'd0, 11'd3}, 4'hF);
    wr(8'h2C, 32'h7F, 4'h1);
    start_frame();
    run_pixels(2);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("arst_en", 32'(filt_en), 32'd0);
    check("arst_fs", 32'(frame_start), 32'd0);
    check("arst_irq", 32'(irq), 32'd0);
    chk_cfg("arst");
    step();
    rst_n = 1'b1;
    step();
    rd_chk(8'h0C, "post_rst_dim");
    rd_chk(8'h2C, "post_rst_coef3");
    rd_chk(8'h14, "post_rst_pix");
    wr(8'h0C, {5'd0, 11'd2, 5'd0, 11'd3}, 4'hF);
    wr(8'h00, 32'h4, 4'h1);
    start_frame();
    finish_frame();
    chk_cfg("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
